// File: rtl/pipelined_grand_adder.sv
// pipelined_grand_adder: chunked carry-propagate FMA grand adder with sign fix-up and valid/ready stall
module pipelined_grand_adder #(
    parameter int PARM_EXP   = 8,
    parameter int PARM_MANT  = 23,
    parameter int NUM_CHUNKS = 3
) (
    input  logic                   Clk_i,
    input  logic                   Rst_ni,
    input  logic                   Flush_i,
    input  logic                   In_valid_i,
    output logic                   In_ready_o,
    input  logic [2*PARM_MANT+1:0] CSA_sum_i,
    input  logic [2*PARM_MANT+1:0] CSA_carry_i,
    input  logic                   Carry_in_i,
    input  logic [PARM_MANT+3:0]   A_Mant_aligned_high_i,
    input  logic                   Sub_Sign_i,
    input  logic                   Exp_mv_sign_i,
    input  logic                   Mv_halt_i,
    input  logic                   Sign_aligned_i,
    input  logic                   BC_special_i,
    output logic                   Out_valid_o,
    input  logic                   Out_ready_i,
    output logic [3*PARM_MANT+4:0] PosSum_o,
    output logic                   Adder_sign_o,
    output logic                   Sign_flip_o,
    output logic                   Minus_sticky_bit_o
);
    localparam int LW = 2 * PARM_MANT + 2;
    localparam int HW = PARM_MANT + 4;
    localparam int W  = LW + HW;
    localparam int OW = W - 1;
    localparam int CW = (W + NUM_CHUNKS - 1) / NUM_CHUNKS;

    typedef struct packed {
        logic [HW-2:0] a;
        logic          sub;
        logic          emv;
        logic          halt;
        logic          sgn;
        logic          bc;
    } ctl_t;

    logic          adv;
    logic [W-1:0]  x_in, y_in;
    ctl_t          ctl_in;

    assign adv        = !Out_valid_o || Out_ready_i;
    assign In_ready_o = adv;
    // addend high and CSA sum occupy disjoint bit ranges, so they merge into one operand
    assign x_in   = {A_Mant_aligned_high_i, CSA_sum_i};
    assign y_in   = {{HW{1'b0}}, CSA_carry_i};
    assign ctl_in = {A_Mant_aligned_high_i[HW-2:0], Sub_Sign_i, Exp_mv_sign_i, Mv_halt_i, Sign_aligned_i, BC_special_i};

    if (NUM_CHUNKS < 1 || NUM_CHUNKS > 8 || PARM_EXP < 1) begin : g_bad
        $error("pipelined_grand_adder: unsupported parameters");
    end

    for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_chunk
        localparam int LO = k * CW;
        localparam int HI = (k + 1) * CW < W ? (k + 1) * CW : W;
        localparam int N  = HI - LO;
        logic [W-1:LO] xp, yp;
        logic          cp, vp;
        ctl_t          ctl_p;
        logic [N-1:0]  sum;
        logic [HI-1:0] rn, r_q;
        logic          v_q;
        ctl_t          ctl_q;
        if (k == 0) begin : g_src
            assign xp    = x_in;
            assign yp    = y_in;
            assign cp    = Carry_in_i;
            assign vp    = In_valid_i;
            assign ctl_p = ctl_in;
            assign rn    = sum;
        end else begin : g_src
            assign xp    = g_chunk[k-1].g_mid.x_q;
            assign yp    = g_chunk[k-1].g_mid.y_q;
            assign cp    = g_chunk[k-1].g_mid.c_q;
            assign vp    = g_chunk[k-1].v_q;
            assign ctl_p = g_chunk[k-1].ctl_q;
            assign rn    = {sum, g_chunk[k-1].r_q};
        end
        if (k < NUM_CHUNKS - 1) begin : g_mid
            logic [N:0]    s;
            logic [W-1:HI] x_q, y_q;
            logic          c_q;
            assign s   = {1'b0, xp[HI-1:LO]} + {1'b0, yp[HI-1:LO]} + (N+1)'(cp);
            assign sum = s[N-1:0];
            always_ff @(posedge Clk_i or negedge Rst_ni)
                if (!Rst_ni) begin
                    x_q <= '0;
                    y_q <= '0;
                    c_q <= 1'b0;
                end else if (adv) begin
                    x_q <= xp[W-1:HI];
                    y_q <= yp[W-1:HI];
                    c_q <= s[N];
                end
        end else begin : g_last
            assign sum = xp[HI-1:LO] + yp[HI-1:LO] + N'(cp);
        end
        always_ff @(posedge Clk_i or negedge Rst_ni)
            if (!Rst_ni) begin
                r_q   <= '0;
                ctl_q <= '0;
                v_q   <= 1'b0;
            end else begin
                if (adv) begin
                    r_q   <= rn;
                    ctl_q <= ctl_p;
                end
                v_q <= Flush_i ? 1'b0 : adv ? vp : v_q;
            end
    end

    logic [W-1:0]  r;
    ctl_t          c;
    logic          vl, flip;
    logic [HW-1:0] top;
    logic [OW-1:0] pos;

    assign r  = g_chunk[NUM_CHUNKS-1].r_q;
    assign c  = g_chunk[NUM_CHUNKS-1].ctl_q;
    assign vl = g_chunk[NUM_CHUNKS-1].v_q;

    always_comb begin
        flip = r[W-1];
        top  = {c.a, 1'b0} - HW'(!c.bc);
        pos  = c.halt ? OW'(r[LW-1:0]) :
               c.emv  ? (c.sub ? {top, {(LW-1){1'b0}}} : {c.a, {LW{1'b0}}}) :
               flip   ? {OW{1'b0}} - r[OW-1:0] : r[OW-1:0];
    end

    always_ff @(posedge Clk_i or negedge Rst_ni)
        if (!Rst_ni) begin
            Out_valid_o        <= 1'b0;
            PosSum_o           <= '0;
            Adder_sign_o       <= 1'b0;
            Sign_flip_o        <= 1'b0;
            Minus_sticky_bit_o <= 1'b0;
        end else begin
            Out_valid_o <= Flush_i ? 1'b0 : adv ? vl : Out_valid_o;
            if (adv && vl && !Flush_i) begin
                PosSum_o           <= pos;
                Adder_sign_o       <= c.emv ? c.sgn : flip ^ c.sgn;
                Sign_flip_o        <= flip;
                Minus_sticky_bit_o <= c.emv && !c.bc;
            end
        end
endmodule

// File: tb/tb_pipelined_grand_adder.sv
// tb_pipelined_grand_adder: scoreboard bench over three chunk counts sharing one clock
module tb_pipelined_grand_adder;
    localparam int M  = 23;
    localparam int LW = 2 * M + 2;
    localparam int HW = M + 4;
    localparam int W  = LW + HW;
    localparam int OW = W - 1;

    typedef struct packed {
        logic [HW-1:0] a;
        logic [LW-1:0] sum;
        logic [LW-1:0] carry;
        logic          cin, sub, emv, halt, sgn, bc;
    } beat_t;

    typedef struct packed {
        logic [OW-1:0] pos;
        logic          sign, flip, sticky;
    } exp_t;

    logic       clk = 1'b0;
    logic [3:0] pat = 4'b1001;
    int         checks = 0, errors = 0, cyc = 0, done_cnt = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input beat_t b);
        exp_t          e;
        logic [W-1:0]  r;
        logic [HW-1:0] top;
        longint        ahalf;
        r     = {b.a, {LW{1'b0}}} + W'(b.sum) + W'(b.carry) + W'(b.cin);
        ahalf = longint'(b.a) % (longint'(1) << (HW - 1));
        e.flip   = r[W-1];
        e.sign   = b.emv ? b.sgn : (e.flip ^ b.sgn);
        e.sticky = b.emv && !b.bc;
        if (b.halt) e.pos = OW'(r % (W'(1) << LW));
        else if (b.emv && b.sub) begin
            top   = HW'(2 * ahalf - (b.bc ? 1 - 1 : 1));
            e.pos = OW'(top) << (LW - 1);
        end
        else if (b.emv) e.pos = OW'(ahalf) << LW;
        else if (e.flip) e.pos = OW'(W'(0) - r);
        else e.pos = OW'(r);
        return e;
    endfunction

    function automatic beat_t mk(input logic [HW-1:0] a, input logic [LW-1:0] s, input logic [LW-1:0] c,
                                 input logic ci, input logic su, input logic em, input logic ha,
                                 input logic sg, input logic bcs);
        beat_t b;
        b = {a, s, c, ci, su, em, ha, sg, bcs};
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int    sel = $urandom_range(0, 7);
        b.a     = HW'({$urandom, $urandom});
        b.sum   = LW'({$urandom, $urandom});
        b.carry = LW'({$urandom, $urandom});
        b.cin   = 1'($urandom_range(0, 1));
        b.sub   = 1'($urandom_range(0, 1));
        b.sgn   = 1'($urandom_range(0, 1));
        b.bc    = 1'($urandom_range(0, 1));
        b.halt  = sel == 0;
        b.emv   = sel == 1 || sel == 2;
        return b;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NC = g == 0 ? 3 : g == 1 ? 1 : 8;
        logic          rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
        logic          cin = 1'b0, sub = 1'b0, emv = 1'b0, halt = 1'b0, sgn = 1'b0, bc = 1'b0;
        logic          in_ready, out_valid, sign, flip, sticky;
        logic [LW-1:0] sum = '0, carry = '0;
        logic [HW-1:0] a = '0;
        logic [OW-1:0] pos;
        int            rmode = 0, acc_cyc = 0;
        exp_t          q[$];

        pipelined_grand_adder #(.PARM_EXP(8), .PARM_MANT(M), .NUM_CHUNKS(NC)) dut (
            .Clk_i(clk), .Rst_ni(rst_n), .Flush_i(flush), .In_valid_i(in_valid), .In_ready_o(in_ready),
            .CSA_sum_i(sum), .CSA_carry_i(carry), .Carry_in_i(cin), .A_Mant_aligned_high_i(a),
            .Sub_Sign_i(sub), .Exp_mv_sign_i(emv), .Mv_halt_i(halt), .Sign_aligned_i(sgn),
            .BC_special_i(bc), .Out_valid_o(out_valid), .Out_ready_i(out_ready), .PosSum_o(pos),
            .Adder_sign_o(sign), .Sign_flip_o(flip), .Minus_sticky_bit_o(sticky)
        );

        function automatic string nm(input string s);
            return $sformatf("nc%0d_%s", NC, s);
        endfunction

        initial forever begin
            @(posedge clk);
            #1;
            out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? pat[cyc % 4] : rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
        end

        always @(negedge clk) begin : mon
            exp_t e;
            logic rdy;
            if (rst_n) begin
                rdy = !out_valid || out_ready;
                chk(nm("in_ready"), in_ready, rdy);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL %s: got valid output, expected none", nm("unexpected_out"));
                    end else begin
                        e = q.pop_front();
                        chk(nm("pos"), pos, e.pos);
                        chk(nm("sign"), sign, e.sign);
                        chk(nm("flip"), flip, e.flip);
                        chk(nm("sticky"), sticky, e.sticky);
                    end
                end
            end
        end

        task automatic drive(input beat_t b);
            a = b.a; sum = b.sum; carry = b.carry; cin = b.cin;
            sub = b.sub; emv = b.emv; halt = b.halt; sgn = b.sgn; bc = b.bc;
        endtask

        task automatic send(input beat_t b);
            int t = 0;
            drive(b);
            in_valid = 1'b1;
            @(negedge clk);
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (in_ready) begin
                q.push_back(model(b));
                acc_cyc = cyc;
            end else begin
                checks++;
                errors++;
                $display("FAIL %s: in_ready=0, expected 1 within 200 cycles", nm("accept"));
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        endtask

        task automatic idle(input int n);
            repeat (n) @(posedge clk);
            #1;
        endtask

        task automatic lat(input beat_t b);
            int t = 0;
            send(b);
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk(nm("latency"), cyc - acc_cyc, NC + 1);
            idle(1);
        endtask

        task automatic quiet(input int n);
            int seen = 0;
            repeat (n) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk(nm("no_stale"), seen, 0);
            idle(1);
        endtask

        task automatic drain();
            int t = 0;
            rmode = 0;
            idle(1);
            while (q.size() != 0 && t < 300) begin
                @(posedge clk);
                t++;
            end
            #1;
            chk(nm("drain"), q.size(), 0);
        endtask

        initial begin
            repeat (3) @(posedge clk);
            #1;
            chk(nm("rst_valid"), out_valid, 0);
            chk(nm("rst_pos"), pos, 0);
            chk(nm("rst_sign"), sign, 0);
            chk(nm("rst_flip"), flip, 0);
            chk(nm("rst_sticky"), sticky, 0);
            chk(nm("rst_ready"), in_ready, 1);
            @(negedge clk);
            rst_n = 1'b1;
            idle(1);
            lat(mk('0, 5, 3, 1, 0, 0, 0, 1, 0));
            send(mk('1, '1, '0, 0, 0, 0, 0, 1, 0));
            send(mk(4, '0, '0, 0, 1, 1, 0, 0, 0));
            send(mk(4, '0, '0, 0, 1, 1, 0, 0, 1));
            send(mk(4, '0, '0, 0, 0, 1, 0, 1, 0));
            send(mk('0, '0, '0, 0, 1, 1, 0, 0, 0));
            send(mk(27'h7FFFFFF, 'h123, 'h100, 0, 0, 0, 1, 0, 0));
            drain();
            rmode = 1;
            for (int i = 0; i < 10; i++) send(rand_beat());
            drain();
            rmode = 2;
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 2) == 0) idle(1);
                send(rand_beat());
            end
            drain();
            // flush with beats in flight and a simultaneous input beat that must be ignored
            for (int i = 0; i < 3; i++) send(rand_beat());
            drive(rand_beat());
            flush = 1'b1;
            in_valid = 1'b1;
            idle(1);
            flush = 1'b0;
            in_valid = 1'b0;
            q.delete();
            quiet(12);
            lat(rand_beat());
            drain();
            // flush while the output is stalled
            rmode = 3;
            for (int i = 0; i < 2; i++) send(rand_beat());
            idle(NC + 3);
            flush = 1'b1;
            idle(1);
            flush = 1'b0;
            q.delete();
            rmode = 0;
            quiet(10);
            // half-cycle reset pulse mid-stream
            for (int i = 0; i < 2; i++) send(rand_beat());
            rst_n = 1'b0;
            q.delete();
            #3;
            chk(nm("midrst_valid"), out_valid, 0);
            chk(nm("midrst_pos"), pos, 0);
            chk(nm("midrst_ready"), in_ready, 1);
            #2;
            rst_n = 1'b1;
            idle(1);
            quiet(8);
            lat(rand_beat());
            drain();
            done_cnt++;
        end
    end

    initial begin
        for (int c = 0; c < 60000 && done_cnt < 3; c++) @(posedge clk);
        if (done_cnt < 3) begin
            checks++;
            errors++;
            $display("FAIL timeout: finished instances %0d, expected 3", done_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_grand_adder.md
Name: pipelined_grand_adder

Overview:
Parametrised, pipelined successor of the FMA grand-adder stage. It adds the carry-save pair from the Wallace tree to the aligned addend high part, resolves the sign, and produces the positive magnitude for the LZA/normaliser. The full-width carry-propagate add is split into NUM_CHUNKS registered chunk stages, followed by one fix-up stage, with valid/ready handshaking and a global stall. It sits between the CSA/Wallace stage and the LZA.

Parameters:
PARM_EXP, 8, exponent width; sizes nothing internally and is kept for port compatibility with neighbouring stages.
PARM_MANT, 23, mantissa width. LW=2*PARM_MANT+2, HW=PARM_MANT+4, W=LW+HW, OW=3*PARM_MANT+5 (OW=W-1).
NUM_CHUNKS, 3, number of carry-propagate chunk stages, 1..8. CW=ceil(W/NUM_CHUNKS); the last chunk holds the remainder.

Ports:
Clk_i  in  1  clock, rising edge
Rst_ni  in  1  asynchronous active-low reset
Flush_i  in  1  synchronous pipeline clear
In_valid_i  in  1  input beat valid
In_ready_o  out  1  stage can accept a beat
CSA_sum_i  in  LW  carry-save sum vector
CSA_carry_i  in  LW  carry-save carry vector
Carry_in_i  in  1  post-correction carry into bit 0
A_Mant_aligned_high_i  in  HW  aligned addend, high part
Sub_Sign_i  in  1  effective subtraction
Exp_mv_sign_i  in  1  product negligible (addend-only path)
Mv_halt_i  in  1  addend negligible (product-only path)
Sign_aligned_i  in  1  sign of the aligned addend
BC_special_i  in  1  B or C is Inf, Zero or NaN
Out_valid_o  out  1  result valid
Out_ready_i  in  1  downstream accepts the result
PosSum_o  out  OW  positive magnitude
Adder_sign_o  out  1  sign of the result
Sign_flip_o  out  1  raw sum was negative
Minus_sticky_bit_o  out  1  sticky bit for the addend-only path

Behaviour:
- Reset is asynchronous and active-low. It clears every valid flag and all data registers. Outputs during reset: Out_valid_o=0, PosSum_o=0, Adder_sign_o=0, Sign_flip_o=0, Minus_sticky_bit_o=0, In_ready_o=1.
- Latency is NUM_CHUNKS+1 cycles from input acceptance to Out_valid_o. Throughput is one beat per cycle when no stall occurs.
- Stall is global: In_ready_o = ~Out_valid_o | Out_ready_i. When a stall holds, every stage register keeps its value. Handshake rules:
  - A beat transfers in when In_valid_i & In_ready_o; out when Out_valid_o & Out_ready_i.
  - Pipeline bubbles do not compress under stall, which is accepted by design.
- Arithmetic: R = {A_Mant_aligned_high_i, LW'b0} + zero-extended CSA_sum_i + zero-extended CSA_carry_i + Carry_in_i, taken modulo 2^W.
- Chunk stage k (0-based) adds bits [k*CW +: CW] plus the registered carry from stage k-1. Chunk 0 uses Carry_in_i as its carry in. The carry out of the MSB chunk is discarded.
- Operand bits for chunks not yet processed travel forward in skew registers. Control bits travel alongside the beat in a valid-qualified sideband pipe.
- Sign_flip = R[W-1].
- Fix-up stage selects PosSum in this priority order:
  1. Mv_halt: {HW-1 zeros, R[LW-1:0]}.
  2. Exp_mv_sign & Sub_Sign: {({A[HW-2:0],1'b0} - ~BC_special) truncated to HW bits, LW-1 zeros}.
  3. Exp_mv_sign & ~Sub_Sign: {A[HW-2:0], LW zeros}.
  4. Sign_flip: ((2^W - R) mod 2^W) [OW-1:0].
  5. Otherwise: R[OW-1:0].
- Adder_sign = Exp_mv_sign ? Sign_aligned : (Sign_flip ^ Sign_aligned).
- Minus_sticky_bit = Exp_mv_sign & ~BC_special.
- Sign_flip_o reports R[W-1] in every mode.
- Flush_i clears all valid flags on the next edge and has priority over stall and over a simultaneous input beat. Data registers may keep stale values after a flush.
- Output registers change only when a new beat is loaded into the output stage.
- When NUM_CHUNKS=1 the block degenerates to a single add stage plus the fix-up stage (latency 2).
- Reset asserted mid-operation drops all in-flight beats. No output appears for them.

Test Plan:
- Defaults, A=0, sum=5, carry=3, Carry_in=1, all control bits 0 → after 4 cycles: PosSum_o=9, Sign_flip_o=0, Adder_sign_o=Sign_aligned_i.
- A=0, sum=all-ones (LW bits), carry=0, Carry_in=0, Sign_aligned=1, with the HW field sign-extended through A=all-ones → R=-1, Sign_flip_o=1, PosSum_o=1, Adder_sign_o=0.
- Exp_mv_sign=1, Sub_Sign=1, A=0x0000004, BC_special=0 → PosSum_o={0x0000007, 47 zeros}, Minus_sticky_bit_o=1. Repeat with BC_special=1 → top field 0x0000008, Minus_sticky_bit_o=0.
- Mv_halt=1, sum=0x123, carry=0x100, A=0x7FFFFFF → PosSum_o=0x223 (HW-1 zeros above the low field).
- Stream 10 random beats back-to-back with Out_ready_i toggling 1,0,0,1 → the output sequence matches the reference model in order, with no loss or duplication, and In_ready_o=0 only while Out_valid_o=1 and Out_ready_i=0.
- Flush_i pulsed with 3 beats in flight, plus Rst_ni pulsed low for half a cycle mid-stream → no stale Out_valid_o, and the next accepted beat emerges after exactly NUM_CHUNKS+1 cycles. Repeat the whole suite with NUM_CHUNKS=1 and NUM_CHUNKS=8.
